// File: rtl/sd_spi_responder.sv
// SPI-mode SD card model: answers the init sequence and serves CMD17 reads from byte memory.
// Define SDRESP_CRC_CHECK_EN to enforce CRC7 on CMD0/CMD8 frames.
module sd_spi_responder #(
  parameter logic [31:0] CAPACITY_BLOCKS = 32'h0001_0000,
  parameter int          ACMD41_BUSY     = 3,
  parameter int          READ_GAP        = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        spi_cs,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic [40:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  output logic        card_idle,
  output logic        cmd_strobe,
  output logic [5:0]  last_cmd
);

  typedef enum logic [3:0] {
    HUNT, FRAME, EXEC, NCR, RESP, RDGAP, TOKEN, DATA, CRC16
  } state_e;

  localparam logic [7:0] BUSY_L = 8'(ACMD41_BUSY);
  localparam logic [3:0] GAP_L  = 4'(READ_GAP);

  logic cs_meta_q, cs_sync_q, cs_prev_q;
  logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic mosi_meta_q, mosi_sync_q;
  logic sclk_rise, sclk_fall, cs_fall, tx_load;

  logic [2:0] bit_cnt_q, fall_cnt_q;
  logic [7:0] rx_shift_q, rx_byte_q, tx_shift_q, tx_byte;
  logic       rx_done_q;
  logic       fetch_pend_q;
  logic [7:0] data_buf_q;

  state_e      state_q, state_d;
  logic [2:0]  frame_cnt_q, frame_cnt_d;
  logic [5:0]  cmd_idx_q, cmd_idx_d;
  logic [31:0] arg_q, arg_d;
  logic [39:0] resp_q, resp_d;
  logic [2:0]  resp_len_q, resp_len_d;
  logic [2:0]  resp_idx_q, resp_idx_d;
  logic        read_q, read_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic [8:0]  off_q, off_d;
  logic        mem_rd_q, mem_rd_d;
  logic [40:0] mem_addr_q, mem_addr_d;
  logic        idle_q, idle_d;
  logic        app_q, app_d;
  logic [7:0]  acmd_cnt_q, acmd_cnt_d;
  logic        strobe_q, strobe_d;
  logic [5:0]  last_cmd_q, last_cmd_d;
  logic [7:0]  r1;
  logic [31:0] trailer;
  logic        crc_bad;

  assign sclk_rise = sclk_sync_q & ~sclk_prev_q & ~cs_sync_q;
  assign sclk_fall = ~sclk_sync_q & sclk_prev_q & ~cs_sync_q;
  assign cs_fall   = ~cs_sync_q & cs_prev_q;
  assign tx_load   = cs_fall | (sclk_fall & (fall_cnt_q == 3'd7));

  assign spi_miso   = cs_sync_q ? 1'b1 : tx_shift_q[7];
  assign mem_rd     = mem_rd_q;
  assign mem_addr   = mem_addr_q;
  assign card_idle  = idle_q;
  assign cmd_strobe = strobe_q;
  assign last_cmd   = last_cmd_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cs_meta_q    <= 1'b1;
      cs_sync_q    <= 1'b1;
      cs_prev_q    <= 1'b1;
      sclk_meta_q  <= 1'b0;
      sclk_sync_q  <= 1'b0;
      sclk_prev_q  <= 1'b0;
      mosi_meta_q  <= 1'b1;
      mosi_sync_q  <= 1'b1;
      bit_cnt_q    <= 3'd0;
      fall_cnt_q   <= 3'd0;
      rx_shift_q   <= 8'h00;
      rx_byte_q    <= 8'h00;
      rx_done_q    <= 1'b0;
      tx_shift_q   <= 8'hFF;
      fetch_pend_q <= 1'b0;
      data_buf_q   <= 8'h00;
    end else begin
      cs_meta_q    <= spi_cs;
      cs_sync_q    <= cs_meta_q;
      cs_prev_q    <= cs_sync_q;
      sclk_meta_q  <= spi_sclk;
      sclk_sync_q  <= sclk_meta_q;
      sclk_prev_q  <= sclk_sync_q;
      mosi_meta_q  <= spi_mosi;
      mosi_sync_q  <= mosi_meta_q;
      fetch_pend_q <= mem_rd_q;
      if (fetch_pend_q) data_buf_q <= mem_data;
      rx_done_q <= 1'b0;
      if (cs_sync_q) begin
        bit_cnt_q  <= 3'd0;
        fall_cnt_q <= 3'd0;
        tx_shift_q <= 8'hFF;
      end else begin
        if (sclk_rise) begin
          rx_shift_q <= {rx_shift_q[6:0], mosi_sync_q};
          bit_cnt_q  <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_byte_q <= {rx_shift_q[6:0], mosi_sync_q};
            rx_done_q <= 1'b1;
          end
        end
        if (tx_load) begin
          tx_shift_q <= tx_byte;
          fall_cnt_q <= 3'd0;
        end else if (sclk_fall) begin
          tx_shift_q <= {tx_shift_q[6:0], 1'b1};
          fall_cnt_q <= fall_cnt_q + 3'd1;
        end
      end
    end
  end

`ifdef SDRESP_CRC_CHECK_EN
  logic [6:0] crc_q, crc_rx_q;

  function automatic logic [6:0] crc7_byte(input logic [6:0] crc, input logic [7:0] b);
    logic [6:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ b[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // Any HUNT byte restarts the CRC, so a frame start always begins from zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      crc_q    <= 7'h00;
      crc_rx_q <= 7'h00;
    end else if (rx_done_q) begin
      if (state_q == HUNT) begin
        crc_q <= crc7_byte(7'h00, rx_byte_q);
      end else if (state_q == FRAME) begin
        if (frame_cnt_q < 3'd4) crc_q <= crc7_byte(crc_q, rx_byte_q);
        else                    crc_rx_q <= rx_byte_q[7:1];
      end
    end
  end

  assign crc_bad = ((cmd_idx_q == 6'd0) || (cmd_idx_q == 6'd8)) && (crc_q != crc_rx_q);
`else
  assign crc_bad = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HUNT;
      frame_cnt_q <= 3'd0;
      cmd_idx_q   <= 6'd0;
      arg_q       <= 32'd0;
      resp_q      <= 40'hFF_FFFF_FFFF;
      resp_len_q  <= 3'd1;
      resp_idx_q  <= 3'd0;
      read_q      <= 1'b0;
      gap_cnt_q   <= 4'd0;
      off_q       <= 9'd0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= 41'd0;
      idle_q      <= 1'b1;
      app_q       <= 1'b0;
      acmd_cnt_q  <= 8'd0;
      strobe_q    <= 1'b0;
      last_cmd_q  <= 6'd0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      cmd_idx_q   <= cmd_idx_d;
      arg_q       <= arg_d;
      resp_q      <= resp_d;
      resp_len_q  <= resp_len_d;
      resp_idx_q  <= resp_idx_d;
      read_q      <= read_d;
      gap_cnt_q   <= gap_cnt_d;
      off_q       <= off_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      idle_q      <= idle_d;
      app_q       <= app_d;
      acmd_cnt_q  <= acmd_cnt_d;
      strobe_q    <= strobe_d;
      last_cmd_q  <= last_cmd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    cmd_idx_d   = cmd_idx_q;
    arg_d       = arg_q;
    resp_d      = resp_q;
    resp_len_d  = resp_len_q;
    resp_idx_d  = resp_idx_q;
    read_d      = read_q;
    gap_cnt_d   = gap_cnt_q;
    off_d       = off_q;
    mem_rd_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    idle_d      = idle_q;
    app_d       = app_q;
    acmd_cnt_d  = acmd_cnt_q;
    strobe_d    = 1'b0;
    last_cmd_d  = last_cmd_q;
    tx_byte     = 8'hFF;
    r1          = 8'h00;
    trailer     = 32'hFFFF_FFFF;
    if (cs_sync_q) begin
      state_d = HUNT;
      read_d  = 1'b0;
    end else begin
      case (state_q)
        HUNT: begin
          if (rx_done_q && (rx_byte_q[7:6] == 2'b01)) begin
            cmd_idx_d   = rx_byte_q[5:0];
            frame_cnt_d = 3'd0;
            state_d     = FRAME;
          end
        end
        FRAME: begin
          if (rx_done_q) begin
            frame_cnt_d = frame_cnt_q + 3'd1;
            if (frame_cnt_q < 3'd4) arg_d = {arg_q[23:0], rx_byte_q};
            else                    state_d = EXEC;
          end
        end
        EXEC: begin
          strobe_d   = 1'b1;
          last_cmd_d = cmd_idx_q;
          app_d      = 1'b0;
          resp_len_d = 3'd1;
          resp_idx_d = 3'd0;
          read_d     = 1'b0;
          state_d    = NCR;
          if (crc_bad) begin
            r1 = {4'b0, 1'b1, 2'b0, idle_q};
          end else begin
            case (cmd_idx_q)
              6'd0: begin
                idle_d     = 1'b1;
                acmd_cnt_d = 8'd0;
                r1         = 8'h01;
              end
              6'd8: begin
                r1         = {7'b0, idle_q};
                trailer    = {16'h0000, 4'h0, arg_q[11:8], arg_q[7:0]};
                resp_len_d = 3'd5;
              end
              6'd55: begin
                r1    = {7'b0, idle_q};
                app_d = 1'b1;
              end
              6'd41: begin
                if (!app_q) begin
                  r1 = {5'b0, 1'b1, 1'b0, idle_q};
                end else if (acmd_cnt_q < BUSY_L) begin
                  acmd_cnt_d = acmd_cnt_q + 8'd1;
                  r1         = 8'h01;
                end else begin
                  idle_d = 1'b0;
                  r1     = 8'h00;
                end
              end
              6'd58: begin
                r1         = {7'b0, idle_q};
                trailer    = 32'hC0FF_8000;
                resp_len_d = 3'd5;
              end
              6'd17: begin
                if (idle_q)                        r1 = 8'h05;
                else if (arg_q >= CAPACITY_BLOCKS) r1 = 8'h40;
                else begin
                  r1     = 8'h00;
                  read_d = 1'b1;
                end
              end
              default: r1 = {5'b0, 1'b1, 1'b0, idle_q};
            endcase
          end
          resp_d = {r1, trailer};
        end
        NCR: begin
          if (tx_load) state_d = RESP;
        end
        RESP: begin
          if (tx_load) begin
            tx_byte    = resp_q[39:32];
            resp_d     = {resp_q[31:0], 8'hFF};
            resp_idx_d = resp_idx_q + 3'd1;
            gap_cnt_d  = 4'd0;
            if (resp_idx_q == resp_len_q - 3'd1) begin
              if (!read_q)              state_d = HUNT;
              else if (GAP_L == 4'd0)   state_d = TOKEN;
              else                      state_d = RDGAP;
            end
          end
        end
        RDGAP: begin
          if (tx_load) begin
            gap_cnt_d = gap_cnt_q + 4'd1;
            if (gap_cnt_q == GAP_L - 4'd1) state_d = TOKEN;
          end
        end
        TOKEN: begin
          if (tx_load) begin
            tx_byte    = 8'hFE;
            mem_rd_d   = 1'b1;
            mem_addr_d = {arg_q, 9'd0};
            off_d      = 9'd0;
            state_d    = DATA;
          end
        end
        // Each data byte load prefetches the next offset so it is buffered well before its slot.
        DATA: begin
          if (tx_load) begin
            tx_byte = data_buf_q;
            off_d   = off_q + 9'd1;
            if (off_q != 9'd511) begin
              mem_rd_d   = 1'b1;
              mem_addr_d = {arg_q, off_q + 9'd1};
            end else begin
              gap_cnt_d = 4'd0;
              state_d   = CRC16;
            end
          end
        end
        CRC16: begin
          if (tx_load) begin
            gap_cnt_d = gap_cnt_q + 4'd1;
            if (gap_cnt_q == 4'd1) begin
              read_d  = 1'b0;
              state_d = HUNT;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed bench for sd_spi_responder: host-side SPI driver plus a byte memory returning addr[7:0].
module tb_sd_spi_responder;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        spi_cs = 1'b1;
  logic        spi_sclk = 1'b0;
  logic        spi_mosi = 1'b1;
  logic        spi_miso;
  logic [40:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data = 8'h00;
  logic        card_idle;
  logic        cmd_strobe;
  logic [5:0]  last_cmd;

  int compared = 0;
  int mismatched = 0;
  int strobeCount = 0;
  int rdCount = 0;

  sd_spi_responder dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .spi_cs     (spi_cs),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .card_idle  (card_idle),
    .cmd_strobe (cmd_strobe),
    .last_cmd   (last_cmd)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_rd) mem_data <= mem_addr[7:0];
  end

  always @(posedge clock) begin
    if (cmd_strobe) strobeCount <= strobeCount + 1;
    if (mem_rd)     rdCount     <= rdCount + 1;
  end

  task automatic waitClocks(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Mode 0: MOSI set while SCLK low, MISO sampled just before the rising edge.
  task automatic applyStimulus(input logic [7:0] txByte, output logic [7:0] rxByte);
    for (int i = 7; i >= 0; i--) begin
      spi_sclk = 1'b0;
      spi_mosi = txByte[i];
      waitClocks(4);
      rxByte[i] = spi_miso;
      spi_sclk = 1'b1;
      waitClocks(4);
    end
  endtask

  task automatic sendCmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc);
    logic [7:0] b;
    applyStimulus({2'b01, idx}, b);
    applyStimulus(arg[31:24], b);
    applyStimulus(arg[23:16], b);
    applyStimulus(arg[15:8], b);
    applyStimulus(arg[7:0], b);
    applyStimulus(crc, b);
  endtask

  task automatic expectResp(input string tag, input logic [39:0] bytes, input int n);
    logic [7:0] b;
    applyStimulus(8'hFF, b);
    checkOutput({tag, " ncr"}, 64'(b), 64'hFF);
    for (int i = 0; i < n; i++) begin
      applyStimulus(8'hFF, b);
      checkOutput($sformatf("%s byte%0d", tag, i), 64'(b), 64'(bytes[39-8*i -: 8]));
    end
  endtask

  task automatic readPrefix(input string tag);
    logic [7:0] b;
    expectResp(tag, 40'h00_0000_0000, 1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(8'hFF, b);
      checkOutput($sformatf("%s gap%0d", tag, i), 64'(b), 64'hFF);
    end
    applyStimulus(8'hFF, b);
    checkOutput({tag, " token"}, 64'(b), 64'hFE);
  endtask

  initial begin
    logic [7:0] b;
    int rdBefore;

    waitClocks(3);
    checkOutput("reset miso", 64'(spi_miso), 64'd1);
    checkOutput("reset mem_rd", 64'(mem_rd), 64'd0);
    checkOutput("reset mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("reset idle", 64'(card_idle), 64'd1);
    checkOutput("reset strobe", 64'(cmd_strobe), 64'd0);
    checkOutput("reset last_cmd", 64'(last_cmd), 64'd0);
    reset_n = 1'b1;
    waitClocks(4);

    spi_cs = 1'b0;
    waitClocks(8);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(8'hFF, b);
      checkOutput($sformatf("preamble ff%0d", i), 64'(b), 64'hFF);
    end
    checkOutput("preamble strobes", 64'(strobeCount), 64'd0);

    sendCmd(6'd0, 32'h0, 8'h95);
    expectResp("cmd0", 40'h01_0000_0000, 1);
    checkOutput("cmd0 strobes", 64'(strobeCount), 64'd1);
    checkOutput("cmd0 last_cmd", 64'(last_cmd), 64'd0);
    checkOutput("cmd0 idle", 64'(card_idle), 64'd1);

    sendCmd(6'd17, 32'd5, 8'hFF);
    expectResp("cmd17 idle", 40'h05_0000_0000, 1);
    checkOutput("cmd17 last_cmd", 64'(last_cmd), 64'd17);

    sendCmd(6'd8, 32'h0000_01AA, 8'h87);
    expectResp("cmd8", 40'h01_0000_01AA, 5);

    sendCmd(6'd8, 32'h0000_01AA, 8'h00);
`ifdef SDRESP_CRC_CHECK_EN
    expectResp("cmd8 badcrc", 40'h09_0000_0000, 1);
`else
    expectResp("cmd8 nocrc", 40'h01_0000_01AA, 5);
`endif

    for (int k = 0; k < 4; k++) begin
      sendCmd(6'd55, 32'h0, 8'hFF);
      expectResp($sformatf("cmd55 #%0d", k), 40'h01_0000_0000, 1);
      sendCmd(6'd41, 32'h4000_0000, 8'hFF);
      expectResp($sformatf("acmd41 #%0d", k), (k < 3) ? 40'h01_0000_0000 : 40'h00_0000_0000, 1);
    end
    checkOutput("acmd41 idle", 64'(card_idle), 64'd0);

    sendCmd(6'd58, 32'h0, 8'hFF);
    expectResp("cmd58", 40'h00_C0FF_8000, 5);

    sendCmd(6'd17, 32'h0001_0000, 8'hFF);
    expectResp("cmd17 range", 40'h40_0000_0000, 1);

    sendCmd(6'd5, 32'h0, 8'hFF);
    expectResp("cmd5 illegal", 40'h04_0000_0000, 1);

    sendCmd(6'd41, 32'h4000_0000, 8'hFF);
    expectResp("cmd41 noapp", 40'h04_0000_0000, 1);
    checkOutput("noapp idle", 64'(card_idle), 64'd0);

    sendCmd(6'd17, 32'd5, 8'hFF);
    readPrefix("read");
    for (int i = 0; i < 512; i++) begin
      applyStimulus(8'hFF, b);
      checkOutput($sformatf("read data%0d", i), 64'(b), 64'(i[7:0]));
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(8'hFF, b);
      checkOutput($sformatf("read crc%0d", i), 64'(b), 64'hFF);
    end
    checkOutput("read fetches", 64'(rdCount), 64'd512);
    checkOutput("read lba", 64'(mem_addr[40:9]), 64'd5);
    checkOutput("read last offset", 64'(mem_addr[8:0]), 64'd511);

    sendCmd(6'd17, 32'd5, 8'hFF);
    readPrefix("abort");
    for (int i = 0; i < 100; i++) begin
      applyStimulus(8'hFF, b);
    end
    checkOutput("abort data99", 64'(b), 64'h63);
    spi_sclk = 1'b0;
    waitClocks(6);
    spi_cs = 1'b1;
    waitClocks(6);
    checkOutput("abort miso high", 64'(spi_miso), 64'd1);
    rdBefore = rdCount;
    checkOutput("abort fetches", 64'(rdBefore), 64'd614);
    waitClocks(60);
    checkOutput("abort no fetch", 64'(rdCount), 64'(rdBefore));
    checkOutput("abort miso still high", 64'(spi_miso), 64'd1);

    spi_cs = 1'b0;
    waitClocks(8);
    sendCmd(6'd0, 32'h0, 8'h95);
    expectResp("cmd0 after abort", 40'h01_0000_0000, 1);
    checkOutput("final strobes", 64'(strobeCount), 64'd19);
    checkOutput("final rd count", 64'(rdCount), 64'(rdBefore));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
